// File: rtl/internode_link_vc_if.sv
// internode_link_vc_if
//   Transmit and receive handshake bundle for internode_link_vc.
//   master : the node side. It drives tx_data/tx_valid/tx_vc and rx_ready,
//            and it sees tx_ready and the rx_* flit.
//   slave  : the link model. It takes the flit and offers the receive flit.
//   tx_ready is per VC. Bit v is high while VC v holds at least one credit.
interface internode_link_vc_if #(
  parameter int WIDTH  = 256,
  parameter int NumVC  = 2,
  parameter int VCIdxW = 1
);
  logic [WIDTH-1:0]  tx_data;
  logic              tx_valid;
  logic [VCIdxW-1:0] tx_vc;
  logic [NumVC-1:0]  tx_ready;
  logic [WIDTH-1:0]  rx_data;
  logic              rx_valid;
  logic [VCIdxW-1:0] rx_vc;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, tx_vc, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_vc
  );

  modport slave (
    input  tx_data, tx_valid, tx_vc, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_vc
  );
endinterface

// File: rtl/internode_link_vc.sv
// internode_link_vc
//   Fixed-latency inter-node link that is split into NumVC virtual channels.
//   Each VC has its own receive FIFO and uses credit flow control. Credits
//   come back over a return line with the same latency as the data path.
//   Round-robin arbitration chooses which receive VC is presented.
//   Ports:
//     clk, rst      : clock and synchronous active-high reset
//     link (slave)  : tx_data/tx_valid/tx_vc/tx_ready and rx_data/rx_valid/rx_vc/rx_ready
//     util          : busy fraction of the last UtilWindow cycles (255 = 100%)
//     err_overflow  : sticky flag. It sets when a flit reaches a full receive FIFO.
module internode_link_vc #(
  parameter int WIDTH       = 256,
  parameter int DELAY       = 20,
  parameter int NumVC       = 2,
  parameter int VCIdxW      = (NumVC > 1) ? $clog2(NumVC) : 1,
  parameter int RxFIFODepth = 8,
  parameter int UtilWindow  = 256
) (
  input  logic               clk,
  input  logic               rst,
  internode_link_vc_if.slave link,
  output logic [7:0]         util,
  output logic               err_overflow
);
  localparam int CredW     = $clog2(RxFIFODepth + 1);
  localparam int PtrW      = (RxFIFODepth > 1) ? $clog2(RxFIFODepth) : 1;
  localparam int WinW      = $clog2(UtilWindow);
  localparam int UtilShift = WinW - 8;
  localparam logic [CredW-1:0] DepthC = CredW'(RxFIFODepth);

  logic [CredW-1:0]  credit    [NumVC];
  logic [CredW-1:0]  fifo_cnt  [NumVC];
  logic [PtrW-1:0]   rd_ptr    [NumVC];
  logic [PtrW-1:0]   wr_ptr    [NumVC];
  logic [WIDTH-1:0]  mem       [NumVC][RxFIFODepth];

  logic              fwd_valid [DELAY];
  logic [VCIdxW-1:0] fwd_vc    [DELAY];
  logic [WIDTH-1:0]  fwd_data  [DELAY];
  logic              ret_valid [DELAY];
  logic [VCIdxW-1:0] ret_vc    [DELAY];

  logic [VCIdxW-1:0] rr_ptr;
  logic [VCIdxW-1:0] sel;
  logic              found;
  logic              pop;
  logic              vc_ok;
  logic              accept;
  logic [NumVC-1:0]  wr_en, pop_en, push_ok, ret_en, acc_en;
  int                idx;

  logic [WinW-1:0]   win_cnt;
  logic [WinW:0]     busy;
  logic [WinW:0]     busy_total;
  logic [WinW:0]     util_scaled;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(RxFIFODepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // The ready bits come straight from the credit registers. The accept path
  // reads credit as well. It does not read tx_ready, so no combinational
  // loop goes through the interface.
  always_comb begin
    link.tx_ready = '0;
    for (int v = 0; v < NumVC; v++) begin
      link.tx_ready[v] = (credit[v] != '0);
    end
  end

  assign vc_ok  = ({1'b0, link.tx_vc} < (VCIdxW + 1)'(NumVC));
  assign accept = link.tx_valid && vc_ok && (credit[link.tx_vc] != '0);

  // The scan starts at the round-robin pointer and wraps. The first
  // non-empty VC wins. rx_data is zero while nothing is presented.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NumVC; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NumVC) idx = idx - NumVC;
      if (!found && (fifo_cnt[idx] != '0)) begin
        found = 1'b1;
        sel   = VCIdxW'(idx);
      end
    end
    link.rx_valid = found;
    link.rx_vc    = sel;
    link.rx_data  = found ? mem[sel][rd_ptr[sel]] : '0;
  end

  // Per-VC strobes. A FIFO that is full can still take a write when it is
  // popped in the same cycle, because the pop frees the slot first.
  always_comb begin
    pop     = found && link.rx_ready;
    wr_en   = '0;
    pop_en  = '0;
    push_ok = '0;
    ret_en  = '0;
    acc_en  = '0;
    for (int v = 0; v < NumVC; v++) begin
      wr_en[v]   = fwd_valid[DELAY-1] && (fwd_vc[DELAY-1] == VCIdxW'(v));
      pop_en[v]  = pop && (sel == VCIdxW'(v));
      push_ok[v] = wr_en[v] && ((fifo_cnt[v] != DepthC) || pop_en[v]);
      ret_en[v]  = ret_valid[DELAY-1] && (ret_vc[DELAY-1] == VCIdxW'(v));
      acc_en[v]  = accept && (link.tx_vc == VCIdxW'(v));
    end
  end

  // The valid bits of both delay lines are cleared on reset. This drops
  // every flit and credit token that is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        fwd_valid[i] <= 1'b0;
        ret_valid[i] <= 1'b0;
      end
    end else begin
      fwd_valid[0] <= accept;
      ret_valid[0] <= pop;
      for (int i = 1; i < DELAY; i++) begin
        fwd_valid[i] <= fwd_valid[i-1];
        ret_valid[i] <= ret_valid[i-1];
      end
    end
  end

  // The payload shifts without reset, because the valid bits qualify it.
  always_ff @(posedge clk) begin
    fwd_data[0] <= link.tx_data;
    fwd_vc[0]   <= link.tx_vc;
    ret_vc[0]   <= sel;
    for (int i = 1; i < DELAY; i++) begin
      fwd_data[i] <= fwd_data[i-1];
      fwd_vc[i]   <= fwd_vc[i-1];
      ret_vc[i]   <= ret_vc[i-1];
    end
    for (int v = 0; v < NumVC; v++) begin
      if (push_ok[v]) mem[v][wr_ptr[v]] <= fwd_data[DELAY-1];
    end
  end

  assign busy_total  = busy + (WinW + 1)'(accept);
  assign util_scaled = busy_total >> UtilShift;

  // FIFO pointers, credits, arbitration pointer and the utilisation window.
  // When a returning token and an accept land on the same VC together, they
  // cancel. The credit never rises above the FIFO depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NumVC; v++) begin
        credit[v]   <= DepthC;
        fifo_cnt[v] <= '0;
        rd_ptr[v]   <= '0;
        wr_ptr[v]   <= '0;
      end
      rr_ptr       <= '0;
      err_overflow <= 1'b0;
      win_cnt      <= '0;
      busy         <= '0;
      util         <= '0;
    end else begin
      for (int v = 0; v < NumVC; v++) begin
        if (push_ok[v]) wr_ptr[v] <= ptr_next(wr_ptr[v]);
        if (pop_en[v])  rd_ptr[v] <= ptr_next(rd_ptr[v]);
        if (push_ok[v] && !pop_en[v])      fifo_cnt[v] <= fifo_cnt[v] + CredW'(1);
        else if (!push_ok[v] && pop_en[v]) fifo_cnt[v] <= fifo_cnt[v] - CredW'(1);
        if (ret_en[v] && !acc_en[v] && (credit[v] != DepthC)) credit[v] <= credit[v] + CredW'(1);
        else if (!ret_en[v] && acc_en[v])                     credit[v] <= credit[v] - CredW'(1);
      end
      if (|(wr_en & ~push_ok)) err_overflow <= 1'b1;
      if (pop) rr_ptr <= (sel == VCIdxW'(NumVC - 1)) ? '0 : sel + VCIdxW'(1);
      win_cnt <= win_cnt + WinW'(1);
      if (&win_cnt) begin
        util <= (util_scaled > (WinW + 1)'(255)) ? 8'hFF : util_scaled[7:0];
        busy <= '0;
      end else begin
        busy <= busy_total;
      end
    end
  end
endmodule

// File: tb/tb_internode_link_vc.sv
// tb_internode_link_vc
//   Self-checking bench for internode_link_vc.
//   Instance dut  : DELAY=4, NumVC=2, depth=4. The bench follows it with a
//                   time-stamped queue model of flits, tokens and receive
//                   entries.
//   Instance dut_b: DELAY=2, depth=8. Its round trip is short enough that
//                   the utilisation figure can reach 100%.
module tb_internode_link_vc;
  localparam int W   = 32;
  localparam int D   = 4;
  localparam int NV  = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_b;
  logic [7:0] util_a, util_b;
  logic       err_a, err_b;

  internode_link_vc_if #(.WIDTH(W), .NumVC(NV), .VCIdxW(1)) link_a ();
  internode_link_vc_if #(.WIDTH(W), .NumVC(NV), .VCIdxW(1)) link_b ();

  internode_link_vc #(.WIDTH(W), .DELAY(D), .NumVC(NV), .VCIdxW(1),
                      .RxFIFODepth(DEP), .UtilWindow(256)) dut (
    .clk(clk), .rst(rst), .link(link_a.slave), .util(util_a), .err_overflow(err_a));

  internode_link_vc #(.WIDTH(W), .DELAY(2), .NumVC(NV), .VCIdxW(1),
                      .RxFIFODepth(8), .UtilWindow(256)) dut_b (
    .clk(clk), .rst(rst_b), .link(link_b.slave), .util(util_b), .err_overflow(err_b));

  int tests_run, tests_failed;
  bit checks_on, b_done;

  typedef struct { logic [W-1:0] data; int vc; int due; } flit_t;
  typedef struct { int vc; int due; } tok_t;
  typedef struct { int vc; logic [W-1:0] data; } rx_t;

  flit_t fwd_q[$];
  tok_t  tok_q[$];
  rx_t   rx_q[$];
  int    m_credit [NV];
  int    m_rr, m_wc, m_busy, m_util, m_edge;
  bit    m_err;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int occ(input int v);
    int n = 0;
    foreach (rx_q[i]) if (rx_q[i].vc == v) n++;
    return n;
  endfunction

  function automatic int head_idx(input int v);
    foreach (rx_q[i]) if (rx_q[i].vc == v) return i;
    return -1;
  endfunction

  function automatic int model_sel();
    for (int i = 0; i < NV; i++) begin
      if (occ((m_rr + i) % NV) > 0) return (m_rr + i) % NV;
    end
    return -1;
  endfunction

  task automatic compareAll();
    int s, n;
    logic [NV-1:0] exp_rdy;
    s = model_sel();
    for (int v = 0; v < NV; v++) exp_rdy[v] = (m_credit[v] > 0);
    checkOutput("tx_ready", link_a.tx_ready, exp_rdy);
    checkOutput("rx_valid", link_a.rx_valid, s >= 0);
    if (s >= 0) begin
      checkOutput("rx_vc", link_a.rx_vc, s);
      checkOutput("rx_data", link_a.rx_data, rx_q[head_idx(s)].data);
    end else begin
      checkOutput("rx_data_idle", link_a.rx_data, 0);
    end
    checkOutput("util", util_a, m_util);
    checkOutput("err_overflow", err_a, m_err);
    for (int v = 0; v < NV; v++) begin
      checkOutput("credit", dut.credit[v], m_credit[v]);
      n = int'(dut.credit[v]) + int'(dut.fifo_cnt[v]);
      for (int k = 0; k < D; k++) begin
        if (dut.fwd_valid[k] && dut.fwd_vc[k] == 1'(v)) n++;
        if (dut.ret_valid[k] && dut.ret_vc[k] == 1'(v)) n++;
      end
      checkOutput("credit_sum", n, DEP);
    end
  endtask

  // Advances the model by one clock edge, using the inputs driven for it.
  task automatic modelEdge(input bit r, input bit v, input int vc, input logic [W-1:0] d, input bit rdy);
    int s;
    bit acc;
    flit_t f;
    tok_t t;
    rx_t e;
    if (r) begin
      fwd_q.delete(); tok_q.delete(); rx_q.delete();
      for (int i = 0; i < NV; i++) m_credit[i] = DEP;
      m_rr = 0; m_wc = 0; m_busy = 0; m_util = 0; m_err = 0;
    end else begin
      acc = v && (vc < NV) && (m_credit[vc] > 0);
      s = model_sel();
      if (s >= 0 && rdy) begin
        rx_q.delete(head_idx(s));
        m_rr = (s + 1) % NV;
        t.vc = s; t.due = m_edge + D;
        tok_q.push_back(t);
      end
      while (fwd_q.size() > 0 && fwd_q[0].due == m_edge) begin
        f = fwd_q.pop_front();
        if (occ(f.vc) >= DEP) m_err = 1;
        else begin e.vc = f.vc; e.data = f.data; rx_q.push_back(e); end
      end
      while (tok_q.size() > 0 && tok_q[0].due == m_edge) begin
        t = tok_q.pop_front();
        if (m_credit[t.vc] < DEP) m_credit[t.vc]++;
      end
      if (acc) begin
        m_credit[vc]--;
        f.data = d; f.vc = vc; f.due = m_edge + D;
        fwd_q.push_back(f);
      end
      m_busy += int'(acc);
      if (m_wc == 255) begin
        m_util = (m_busy > 255) ? 255 : m_busy;
        m_busy = 0;
        m_wc = 0;
      end else begin
        m_wc++;
      end
    end
    m_edge++;
  endtask

  // One cycle on dut. The task checks the outputs settled since the last
  // edge, drives the inputs for the next edge and steps the model.
  task automatic applyStimulus(input bit r, input bit v, input int vc, input logic [W-1:0] d, input bit rdy);
    @(negedge clk);
    if (checks_on) compareAll();
    rst             = r;
    link_a.tx_valid = v;
    link_a.tx_vc    = 1'(vc);
    link_a.tx_data  = d;
    link_a.rx_ready = rdy;
    modelEdge(r, v, vc, d, rdy);
    if (r) checks_on = 1;
  endtask

  initial begin : main_seq
    tests_run = 0; tests_failed = 0; checks_on = 0;
    rst = 1'b1;
    link_a.tx_valid = 1'b0; link_a.tx_vc = 1'b0; link_a.tx_data = '0; link_a.rx_ready = 1'b1;
    repeat (3) applyStimulus(1, 0, 0, 0, 1);
    repeat (4) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 32'hA5, 1);
    repeat (12) applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, $urandom, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, $urandom, 0);
    repeat (8) applyStimulus(0, 0, 0, 0, 0);
    repeat (20) applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, i % 2, 32'h100 + i, 0);
    repeat (8) applyStimulus(0, 0, 0, 0, 0);
    repeat (16) applyStimulus(0, 0, 0, 0, 1);
    repeat (40) applyStimulus(0, 1, 0, $urandom, 1);
    repeat (1000) applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom,
                                $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, i % 2, $urandom, 1);
    applyStimulus(1, 1, 0, $urandom, 1);
    repeat (12) applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000 && !b_done; i++) @(posedge clk);
    checkOutput("b_done", b_done, 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Utilisation on dut_b. The first window has an accept every cycle, the
  // second on every other cycle, and the third is idle.
  initial begin : util_seq
    int cnt, exp_u;
    bit vb;
    b_done = 0;
    rst_b = 1'b1;
    link_b.tx_valid = 1'b0; link_b.tx_vc = 1'b0; link_b.tx_data = '0; link_b.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    cnt = 0; exp_u = 0;
    for (int k = 0; k < 768; k++) begin
      @(negedge clk);
      checkOutput("b_util", util_b, exp_u);
      checkOutput("b_tx_ready", link_b.tx_ready, 2'b11);
      checkOutput("b_err", err_b, 0);
      rst_b = 1'b0;
      vb = (k < 256) ? 1'b1 : (k < 512) ? (k % 2 == 0) : 1'b0;
      link_b.tx_valid = vb;
      link_b.tx_vc    = 1'(k % 2);
      link_b.tx_data  = 32'(k);
      cnt += int'(vb);
      if (k % 256 == 255) begin
        exp_u = (cnt > 255) ? 255 : cnt;
        cnt = 0;
      end
    end
    @(negedge clk);
    checkOutput("b_util_final", util_b, exp_u);
    link_b.tx_valid = 1'b0;
    b_done = 1;
  end
endmodule
